// File: rtl/seatbelt_alarm_driver.sv
// seatbelt_alarm_driver: turns the level seatbelt warning into a timed LED/chime alert
// Sequence: IDLE -> DELAY (grace) -> FLASH (blinking LED) -> CHIME (blinking LED + buzzer) -> HOLD (solid LED).
// Ports: clk, rst (async, active high), warn (key on & belt open),
//        led, chime, alarm_active, state_o (0 idle, 1 delay, 2 flash/chime/hold), all registered.
// Optional macro WARN_FILTER_EN: warn must hold a new level for FILT_CYC samples before the FSM sees it.
module seatbelt_alarm_driver #(
  parameter int GRACE_CYC = 16,
  parameter int HALF_CYC  = 4,
  parameter int FLASH_CYC = 32,
  parameter int CHIME_CYC = 64,
  parameter int FILT_CYC  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       warn,
  output logic       led,
  output logic       chime,
  output logic       alarm_active,
  output logic [1:0] state_o
);
  localparam int M1 = GRACE_CYC > HALF_CYC ? GRACE_CYC : HALF_CYC;
  localparam int M2 = FLASH_CYC > CHIME_CYC ? FLASH_CYC : CHIME_CYC;
  localparam int M3 = M1 > M2 ? M1 : M2;
  localparam int MAXP = M3 > FILT_CYC ? M3 : FILT_CYC;
  localparam int W = $clog2(MAXP + 1) + 1;
  localparam logic [W-1:0] G = W'(GRACE_CYC);
  localparam logic [W-1:0] H = W'(HALF_CYC);
  localparam logic [W-1:0] F = W'(FLASH_CYC);
  localparam logic [W-1:0] C = W'(CHIME_CYC);
  typedef enum logic [2:0] {IDLE, DELAY, FLASH, CHIME, HOLD} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n, cnt_inc, tog, tog_n, tog_inc, tog_t;
  logic led_n, chime_n, led_t, w;
`ifdef WARN_FILTER_EN
  localparam logic [W-1:0] FL = W'(FILT_CYC);
  logic [W-1:0] fcnt, fcnt_inc;
  assign fcnt_inc = &fcnt ? fcnt : fcnt + 1'b1;
  // fcnt counts consecutive samples disagreeing with the filtered level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w <= 1'b0;
      fcnt <= '0;
    end else if (warn == w) fcnt <= '0;
    else if (fcnt_inc >= FL) begin
      w <= warn;
      fcnt <= '0;
    end else fcnt <= fcnt_inc;
`else
  assign w = warn;
`endif
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign tog_inc = &tog ? tog : tog + 1'b1;
  assign led_t = tog_inc >= H ? ~led : led;
  assign tog_t = tog_inc >= H ? '0 : tog_inc;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tog_n = tog;
    led_n = led;
    chime_n = 1'b0;
    if (!w) begin
      state_n = IDLE;
      cnt_n = '0;
      tog_n = '0;
      led_n = 1'b0;
    end else
      case (state)
        IDLE: begin
          state_n = DELAY;
          cnt_n = '0;
        end
        // cnt_inc >= G also covers GRACE_CYC=0 with a single DELAY cycle
        DELAY:
          if (cnt_inc >= G) begin
            state_n = FLASH;
            cnt_n = '0;
            tog_n = '0;
            led_n = 1'b1;
          end else cnt_n = cnt_inc;
        FLASH: begin
          led_n = led_t;
          tog_n = tog_t;
          if (cnt_inc >= F) begin
            state_n = CHIME;
            cnt_n = '0;
            chime_n = led_t;
          end else cnt_n = cnt_inc;
        end
        // buzzer follows the LED value being registered this edge
        CHIME:
          if (cnt_inc >= C) begin
            state_n = HOLD;
            cnt_n = '0;
            tog_n = '0;
            led_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
            led_n = led_t;
            tog_n = tog_t;
            chime_n = led_t;
          end
        default: led_n = 1'b1;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tog <= '0;
      led <= 1'b0;
      chime <= 1'b0;
      alarm_active <= 1'b0;
      state_o <= 2'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tog <= tog_n;
      led <= led_n;
      chime <= chime_n;
      alarm_active <= state_n != IDLE && state_n != DELAY;
      state_o <= state_n == IDLE ? 2'd0 : state_n == DELAY ? 2'd1 : 2'd2;
    end
endmodule

// File: tb/tb_seatbelt_alarm_driver.sv
// tb_seatbelt_alarm_driver: directed bench with a run-length reference model for seatbelt_alarm_driver
module tb_seatbelt_alarm_driver;
  localparam int G = 4, H = 2, F = 8, C = 8, FL = 3;
  logic clk = 0, rst = 1, warn = 0;
  logic led, chime, alarm_active;
  logic [1:0] state_o;
  int errors = 0, checks = 0;
  int n = 0;
  bit filt = 0;
  bit hist[$];
  int led_exp[24] = '{0,0,0,0, 1,1,0,0,1,1,0,0, 1,1,0,0,1,1,0,0, 1,1,1,1};
  int chm_exp[24] = '{0,0,0,0, 0,0,0,0,0,0,0,0, 1,1,0,0,1,1,0,0, 0,0,0,0};

  seatbelt_alarm_driver #(.GRACE_CYC(G), .HALF_CYC(H), .FLASH_CYC(F), .CHIME_CYC(C), .FILT_CYC(FL)) dut (
    .clk(clk), .rst(rst), .warn(warn), .led(led), .chime(chime),
    .alarm_active(alarm_active), .state_o(state_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // outputs as a function of how many consecutive edges the (filtered) warn has been seen high
  function automatic void model_out(input int cnt, output int el, output int ec, output int ea, output int es);
    int t, f, g;
    g = G < 1 ? 1 : G;
    el = 0; ec = 0; ea = 0; es = 0;
    if (cnt > 0) begin
      t = cnt - 1;
      if (t < g) es = 1;
      else begin
        f = t - g;
        ea = 1;
        es = 2;
        el = (f >= F + C) ? 1 : (((f / H) % 2) == 0 ? 1 : 0);
        ec = (f >= F && f < F + C) ? el : 0;
      end
    end
  endfunction

  initial forever begin
    bit weff;
    @(posedge clk or posedge rst);
    if (rst) begin
      n = 0;
      filt = 0;
      hist.delete();
    end else begin
`ifdef WARN_FILTER_EN
      bit same;
      weff = filt;
      hist.push_back(warn);
      if (hist.size() > FL) hist.delete(0);
      same = hist.size() == FL;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
      if (same && hist[0] != filt) filt = hist[0];
`else
      weff = warn;
`endif
      n = weff ? (n < 100000 ? n + 1 : n) : 0;
    end
  end

  initial forever begin
    int el, ec, ea, es;
    @(posedge clk);
    #2;
    if (!rst) begin
      model_out(n, el, ec, ea, es);
      chk("model_led", led, el);
      chk("model_chime", chime, ec);
      chk("model_alarm", alarm_active, ea);
      chk("model_state", state_o, es);
    end
  end

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    step(2);
    chk("rst_led", led, 0);
    chk("rst_chime", chime, 0);
    chk("rst_alarm", alarm_active, 0);
    chk("rst_state", state_o, 0);
    rst = 0;
    step(2);
    // full escalation sequence
    warn = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      chk("seq_led", led, led_exp[i]);
      chk("seq_chime", chime, chm_exp[i]);
      chk("seq_state", state_o, i < 4 ? 1 : 2);
    end
    step(10);
    chk("hold_led", led, 1);
    chk("hold_chime", chime, 0);
    warn = 0;
    step();
    chk("drop_led", led, 0);
    chk("drop_state", state_o, 0);
    step(2);
    // async reset mid-CHIME
    warn = 1;
    step(4 + 8 + 1);
    chk("pre_rst_chime", chime, 1);
    rst = 1;
    #1;
    chk("async_led", led, 0);
    chk("async_chime", chime, 0);
    chk("async_alarm", alarm_active, 0);
    chk("async_state", state_o, 0);
    @(negedge clk);
    rst = 0;
    step();
    chk("restart_state", state_o, 1);
    step(3);
    chk("restart_led_low", led, 0);
    step();
    chk("restart_led_high", led, 1);
    warn = 0;
    step(2);
    // short request never alarms
    warn = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("short_alarm", alarm_active, 0);
    end
    warn = 0;
    step();
    chk("short_state", state_o, 0);
    chk("short_led", led, 0);
    step(2);
    // drop on the FLASH expiry edge
    warn = 1;
    step(12);
    chk("expiry_pre_state", state_o, 2);
    warn = 0;
    step();
    chk("expiry_state", state_o, 0);
    chk("expiry_led", led, 0);
    chk("expiry_chime", chime, 0);
    step(2);
    warn = 1;
    step(4);
    chk("rearm_led_low", led, 0);
    chk("rearm_state", state_o, 1);
    step();
    chk("rearm_led_high", led, 1);
    warn = 0;
    step(2);
`ifdef WARN_FILTER_EN
    warn = 1;
    step();
    warn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("glitch1_state", state_o, 0);
    end
    warn = 1;
    step(2);
    warn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("glitch2_state", state_o, 0);
    end
    warn = 1;
    step(7);
    chk("filt_led_low", led, 0);
    step();
    chk("filt_led_high", led, 1);
    step(20);
    warn = 0;
    step();
    warn = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("filt_hold_led", led, 1);
    end
    warn = 0;
    step(6);
    chk("filt_drop_state", state_o, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seatbelt_alarm_driver.md
Name: seatbelt_alarm_driver

Overview:
- Consumer end of the seatbelt warning line: takes the level warning request (key on, belt open) produced by the seatbelt detector and turns it into a timed driver-facing alert.
- Sequence: grace delay, then flashing LED, then flashing LED plus chime, then a solid LED with the chime muted.
- Sits between the detector and the dashboard LED and buzzer pins.

Parameters:
- GRACE_CYC, 16, cycles warn must stay high before any output activity.
- HALF_CYC, 4, LED half-period in cycles. LED toggles every HALF_CYC cycles.
- FLASH_CYC, 32, cycles spent in FLASH before escalating to CHIME.
- CHIME_CYC, 64, cycles spent in CHIME before falling back to HOLD.
- FILT_CYC, 3, consecutive identical warn samples needed for a level change. Used only with WARN_FILTER_EN.

Ports:
- clk, input, 1, system clock. All logic on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- warn, input, 1, warning request from the detector, synchronous to clk. 1 means key on and belt open.
- led, output, 1, dashboard warning LED, registered.
- chime, output, 1, buzzer enable, registered.
- alarm_active, output, 1, high in FLASH, CHIME or HOLD, registered.
- state_o, output, 2, current state encoding: IDLE=0, DELAY=1, FLASH=2 (FLASH also covers CHIME and HOLD, distinguished by chime and led behaviour). Registered.

Behaviour:
- Reset: rst high clears all state asynchronously, with no clock needed.
  - Result: state IDLE, led=0, chime=0, alarm_active=0, state_o=0, all counters 0.
  - Reset deasserting mid-alarm always restarts from IDLE.
- States: IDLE, DELAY, FLASH, CHIME, HOLD. A single phase counter and a single toggle counter are shared across states.
- IDLE: outputs 0. warn=1 sampled at edge k moves to DELAY at edge k, with the phase counter cleared.
- DELAY: outputs 0. The counter increments each cycle.
  - While warn=1, the state moves to FLASH at edge k+GRACE_CYC.
  - Result: led first goes high GRACE_CYC cycles after warn was first sampled high.
- FLASH: led=1 on entry and toggles every HALF_CYC cycles (phase-continuous). chime=0, alarm_active=1.
  - After FLASH_CYC cycles in FLASH, moves to CHIME.
- CHIME: led keeps toggling without a phase reset. chime equals the next led value, so the buzzer sounds only during LED-on half-periods.
  - After CHIME_CYC cycles, moves to HOLD.
- HOLD: led=1 solid, chime=0, alarm_active=1. Remains in HOLD until warn drops.
- warn=0 sampled in any non-IDLE state forces IDLE at that edge.
  - led, chime and alarm_active are 0 from that edge on.
  - All counters clear. No partial resume: a later warn=1 restarts from DELAY.
- Simultaneous events: warn=0 on the same edge as a timer expiry takes priority, and the state goes to IDLE.
- Parameter edge cases:
  - GRACE_CYC=0 enters FLASH on the edge after DELAY entry, so DELAY lasts 1 cycle.
  - HALF_CYC must be at least 1.
- Counter widths: sized by $clog2 of the largest parameter + 1. Counters saturate, never wrap. No counter runs in HOLD.

Optional Feature:
- Macro: WARN_FILTER_EN.
- Defined:
  - warn passes through a filter before the FSM. The filtered level changes only after FILT_CYC consecutive samples of the new value.
  - Filtered level resets to 0.
  - Adds FILT_CYC cycles of latency to both assertion and deassertion.
  - Single-cycle glitches never start or abort an alarm.
- Undefined: the FSM uses warn directly. The FILT_CYC parameter exists but is unused.

Test Plan:
- Test parameters: GRACE_CYC=4, HALF_CYC=2, FLASH_CYC=8, CHIME_CYC=8, macro off.
- Scenario 1: rst pulse mid-CHIME with warn held high -> led=0, chime=0 immediately without a clock edge. After release, state_o=1 on the first edge with warn=1, then led=1 four edges later.
- Scenario 2: warn rises and is held -> led=0 for 4 edges, then the led pattern 1,1,0,0,1,1,0,0 with chime=0 (FLASH). Then the same led pattern with chime tracking led for 8 cycles (CHIME). Then led=1 solid and chime=0 indefinitely (HOLD).
- Scenario 3: warn high for 3 cycles then low -> led and alarm_active never assert, state_o returns to 0.
- Scenario 4: warn drops on the exact edge FLASH would expire -> IDLE with led=0, and CHIME is never entered. warn re-raised -> a full 4-cycle delay again.
- Scenario 5: WARN_FILTER_EN defined, FILT_CYC=3.
  - 1-cycle and 2-cycle warn pulses -> no state change.
  - 1-cycle low glitch during HOLD -> led stays 1.
  - Sustained warn -> first led=1 at 3+4 cycles after the rise.
